// File: rtl/flash_mspi_burst.sv
// Multi-lane (dual 0xBB / quad 0xEB) SPI flash burst read engine with init sequence.
// Optional continuous-read (XIP) command skipping is enabled by defining FLASH_MSPI_XIP_EN.
module flash_mspi_burst #(
    parameter int IO_LANES     = 2,
    parameter int MAX_BURST    = 16,
    parameter int DUMMY_CYCLES = 1,
    parameter int INIT_CYCLES  = 16,
    localparam int LEN_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             ready,
    input  logic             req,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             done,
    output logic             mspi_cs,
    output logic [3:0]       mspi_io_o,
    output logic [3:0]       mspi_io_oe,
    input  logic [3:0]       mspi_io_i
);

    localparam int CNT_W    = 16;
    localparam int ADDR_CYC = 24 / IO_LANES;
    localparam int MODE_CYC = 8 / IO_LANES;
    localparam int BYTE_CYC = 8 / IO_LANES;

    localparam logic [7:0] CMD_BYTE  = (IO_LANES == 4) ? 8'hEB : 8'hBB;
`ifdef FLASH_MSPI_XIP_EN
    localparam logic [7:0] MODE_BYTE = 8'h20;
    localparam logic       XIP_EN    = 1'b1;
`else
    localparam logic [7:0] MODE_BYTE = 8'h00;
    localparam logic       XIP_EN    = 1'b0;
`endif

    // In dual mode IO2 (WP=0) and IO3 (HOLD=1) are driven statically at all times.
    localparam logic [3:0] LANE_MASK = (IO_LANES == 4) ? 4'b1111 : 4'b0011;
    localparam logic [3:0] STATIC_OE = (IO_LANES == 4) ? 4'b0000 : 4'b1100;
    localparam logic [3:0] STATIC_O  = (IO_LANES == 4) ? 4'b0000 : 4'b1000;
    localparam logic [3:0] IDLE_OE   = (IO_LANES == 4) ? 4'b0001 : 4'b1101;
    localparam logic [3:0] IDLE_O    = (IO_LANES == 4) ? 4'b0001 : 4'b1001;

    typedef enum logic [3:0] {
        S_INIT_SEL,
        S_INIT_ONES,
        S_INIT_GAP,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [39:0]        tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   byte_q, byte_d;
    logic [7:0]         dout_q, dout_d;
    logic               dv_q, dv_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               cs_q, cs_d;
    logic               xip_q, xip_d;
    logic [3:0]         io_o_q, io_o_d;
    logic [3:0]         io_oe_q, io_oe_d;

    // req is a one-cycle pulse taken only in IDLE (ready=1, busy=0); any other req is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        len_d   = len_q;
        byte_d  = byte_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        cs_d    = cs_q;
        xip_d   = xip_q;

        unique case (state_q)
            S_INIT_SEL: begin
                state_d = S_INIT_ONES;
                cnt_d   = CNT_W'(INIT_CYCLES - 1);
                cs_d    = 1'b0;
                xip_d   = 1'b0;
            end
            S_INIT_ONES: begin
                if (cnt_q == '0) begin
                    state_d = S_INIT_GAP;
                    cnt_d   = CNT_W'(1);
                    cs_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INIT_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (req) begin
                    len_d  = len;
                    byte_d = '0;
                    busy_d = 1'b1;
                    cs_d   = 1'b0;
                    if (xip_q) begin
                        state_d = S_ADDR;
                        cnt_d   = CNT_W'(ADDR_CYC - 1);
                        tx_d    = {addr, MODE_BYTE, 8'h00};
                    end else begin
                        state_d = S_CMD;
                        cnt_d   = CNT_W'(7);
                        tx_d    = {CMD_BYTE, addr, MODE_BYTE};
                    end
                end
            end
            S_CMD: begin
                tx_d = tx_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_ADDR;
                    cnt_d   = CNT_W'(ADDR_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADDR: begin
                tx_d = tx_q << IO_LANES;
                if (cnt_q == '0) begin
                    state_d = S_MODE;
                    cnt_d   = CNT_W'(MODE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MODE: begin
                tx_d = tx_q << IO_LANES;
                if (cnt_q == '0) begin
                    if (DUMMY_CYCLES > 0) begin
                        state_d = S_DUMMY;
                        cnt_d   = CNT_W'(DUMMY_CYCLES - 1);
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_W'(BYTE_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DUMMY: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_W'(BYTE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                rx_d = (rx_q << IO_LANES) | {4'b0000, mspi_io_i & LANE_MASK};
                if (cnt_q == '0) begin
                    dout_d = rx_d;
                    dv_d   = 1'b1;
                    cnt_d  = CNT_W'(BYTE_CYC - 1);
                    if (byte_q == len_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cs_d    = 1'b1;
                        xip_d   = XIP_EN;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_INIT_SEL;
            end
        endcase

        // Lane drive is derived from the state being entered so the pins are registered.
        unique case (state_d)
            S_INIT_ONES: begin
                io_oe_d = STATIC_OE | LANE_MASK;
                io_o_d  = STATIC_O | LANE_MASK;
            end
            S_CMD: begin
                io_oe_d = STATIC_OE | 4'b0001;
                io_o_d  = STATIC_O | {3'b000, tx_d[39]};
            end
            S_ADDR, S_MODE: begin
                io_oe_d = STATIC_OE | LANE_MASK;
                io_o_d  = STATIC_O | 4'(tx_d[39 -: IO_LANES]);
            end
            S_DUMMY, S_DATA: begin
                io_oe_d = STATIC_OE;
                io_o_d  = STATIC_O;
            end
            default: begin
                io_oe_d = IDLE_OE;
                io_o_d  = IDLE_O;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_INIT_SEL;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            len_q   <= '0;
            byte_q  <= '0;
            dout_q  <= 8'h00;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            cs_q    <= 1'b1;
            xip_q   <= 1'b0;
            io_o_q  <= IDLE_O;
            io_oe_q <= IDLE_OE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            xip_q   <= xip_d;
            io_o_q  <= io_o_d;
            io_oe_q <= io_oe_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign done       = done_q;
    assign mspi_cs    = cs_q;
    assign mspi_io_o  = io_o_q;
    assign mspi_io_oe = io_oe_q;

endmodule
